// File: rtl/mux_select_unit.sv
// Operand selection: a 2:1 and a 3:1 word mux, each with a combinational
// result and a registered copy one cycle later. The channels share only
// the width parameter.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module mux_select_unit #(
    parameter int WIDTH = `WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    // 2:1 channel
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sel0,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out0_q,
    // 3:1 channel
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    input  logic [1:0]       sel1,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out1_q
);

    logic [WIDTH-1:0] out0_d;
    logic [WIDTH-1:0] out1_d;

    // 2:1 select, zero latency
    always_comb begin
        out0_d = sel0 ? b0 : a0;
    end

    // 3:1 select; the spare code 2'b11 yields zeros so the output is never X
    always_comb begin
        out1_d = '0;
        case (sel1)
            2'b00:   out1_d = a1;
            2'b01:   out1_d = b1;
            2'b10:   out1_d = c1;
            default: out1_d = '0;
        endcase
    end

    assign out0 = out0_d;
    assign out1 = out1_d;

    // One-cycle registered copies; async reset drops both to zero at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            out0_q <= out0_d;
            out1_q <= out1_d;
        end
    end

endmodule

// File: tb/tb_mux_select_unit.sv
// Bench for mux_select_unit: directed vector table, hand-written reset and
// independence sequences, then random stimulus against a reference model.
module tb_mux_select_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a0, b0, a1, b1, c1;
    logic         sel0;
    logic [1:0]   sel1;
    logic [W-1:0] out0, out0_q, out1, out1_q;

    int total = 0;
    int bad   = 0;

    mux_select_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a0    (a0),
        .b0    (b0),
        .sel0  (sel0),
        .out0  (out0),
        .out0_q(out0_q),
        .a1    (a1),
        .b1    (b1),
        .c1    (c1),
        .sel1  (sel1),
        .out1  (out1),
        .out1_q(out1_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s0;
        logic [1:0]   s1;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: index a table of candidates; slot 3 holds the spare-code zero
    function automatic logic [W-1:0] ref3(input logic [1:0] s, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] z);
        logic [W-1:0] pick [4];
        pick[0] = x; pick[1] = y; pick[2] = z; pick[3] = '0;
        return pick[s];
    endfunction

    function automatic logic [W-1:0] ref2(input logic s, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        logic [W-1:0] pick [2];
        pick[0] = x; pick[1] = y;
        return pick[s];
    endfunction

    vec_t vt [6];
    logic [W-1:0] e0, e1;

    initial begin
        rst_n = 1'b0;
        a0 = 32'h0; b0 = 32'hFFFFFFFF; sel0 = 1'b1;
        a1 = 32'h0; b1 = 32'hFFFFFFFF; c1 = 32'h55555555; sel1 = 2'b01;

        // Reset state, held across edges with nonzero selections
        #1;
        check("reset_out0_q", out0_q, '0);
        check("reset_out1_q", out1_q, '0);
        check("reset_out0_comb", out0, 32'hFFFFFFFF);
        @(posedge clk); #1;
        check("reset_hold_out0_q", out0_q, '0);
        check("reset_hold_out1_q", out1_q, '0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed table from the required select patterns
        vt[0] = '{1'b0, 2'b00, 32'h0,        32'h0};
        vt[1] = '{1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[2] = '{1'b0, 2'b10, 32'h0,        32'h55555555};
        vt[3] = '{1'b1, 2'b11, 32'hFFFFFFFF, 32'h0};
        vt[4] = '{1'b0, 2'b11, 32'h0,        32'h0};
        vt[5] = '{1'b1, 2'b10, 32'hFFFFFFFF, 32'h55555555};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sel0 = vt[i].s0; sel1 = vt[i].s1;
            #1;
            check($sformatf("vec%0d_out0", i), out0, vt[i].e0);
            check($sformatf("vec%0d_out1", i), out1, vt[i].e1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_out0_q", i), out0_q, vt[i].e0);
            check($sformatf("vec%0d_out1_q", i), out1_q, vt[i].e1);
        end

        // Independence: toggle sel0 with sel1 held at 10
        @(negedge clk);
        sel1 = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel0 = ~sel0;
            #1;
            check("indep_out1", out1, 32'h55555555);
            check("indep_out0", out0, sel0 ? 32'hFFFFFFFF : 32'h0);
            @(posedge clk); #1;
            check("indep_out1_q", out1_q, 32'h55555555);
        end

        // Mid-run reset between edges
        @(negedge clk);
        sel0 = 1'b1; sel1 = 2'b01;
        @(posedge clk); #1;
        check("pre_rst_out0_q", out0_q, 32'hFFFFFFFF);
        check("pre_rst_out1_q", out1_q, 32'hFFFFFFFF);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out0_q", out0_q, '0);
        check("midrst_out1_q", out1_q, '0);
        check("midrst_out0", out0, 32'hFFFFFFFF);
        @(posedge clk); #1;
        check("midrst_hold_out0_q", out0_q, '0);

        // Release: first edge reloads from current selections
        @(negedge clk);
        rst_n = 1'b1;
        sel1 = 2'b10;
        #1;
        check("release_no_edge_out0_q", out0_q, '0);
        @(posedge clk); #1;
        check("release_out0_q", out0_q, 32'hFFFFFFFF);
        check("release_out1_q", out1_q, 32'h55555555);

        // Random stimulus against the reference model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; c1 = $urandom;
            sel0 = 1'($urandom_range(0, 1));
            sel1 = 2'($urandom_range(0, 3));
            e0 = ref2(sel0, a0, b0);
            e1 = ref3(sel1, a1, b1, c1);
            #1;
            check("rnd_out0", out0, e0);
            check("rnd_out1", out1, e1);
            @(posedge clk); #1;
            check("rnd_out0_q", out0_q, e0);
            check("rnd_out1_q", out1_q, e1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
